// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for an in-order RV32I pipeline: load-use stall, operand
// forward selects for decode and execute, and a registered writeback port.
module pipe_hazard_ctrl #(
   parameter  int DEPTH    = 3,
   parameter  int LOAD_LAT = 1,
   localparam int FW       = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [31:0]   in_inst,
   input  logic          redirect,
   output logic          stall,
   output logic [FW-1:0] fwd1_s0,
   output logic [FW-1:0] fwd2_s0,
   output logic [FW-1:0] fwd1_s1,
   output logic [FW-1:0] fwd2_s1,
   output logic          wb_en,
   output logic [4:0]    wb_rd,
   output logic [31:0]   stall_cnt
);

   typedef enum logic [4:0] {
      OP_LOAD   = 5'd0,
      OP_IMM    = 5'd4,
      OP_AUIPC  = 5'd5,
      OP_STORE  = 5'd8,
      OP_REG    = 5'd12,
      OP_LUI    = 5'd13,
      OP_BRANCH = 5'd24,
      OP_JALR   = 5'd25,
      OP_JAL    = 5'd27,
      OP_CSRW   = 5'd28
   } opcode_e;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wen;
      logic       is_load;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       use1;
      logic       use2;
   } stage_t;

   function automatic stage_t decode(input logic [31:0] inst);
      stage_t s;
      s       = '0;
      s.valid = 1'b1;
      s.rd    = inst[11:7];
      s.rs1   = inst[19:15];
      s.rs2   = inst[24:20];
      case (inst[6:2])
         OP_LOAD:                 begin s.wen = 1'b1; s.is_load = 1'b1; s.use1 = 1'b1; end
         OP_IMM, OP_JALR:         begin s.wen = 1'b1; s.use1 = 1'b1; end
         OP_AUIPC, OP_LUI, OP_JAL: s.wen = 1'b1;
         OP_REG:                  begin s.wen = 1'b1; s.use1 = 1'b1; s.use2 = 1'b1; end
         OP_STORE, OP_BRANCH:     begin s.use1 = 1'b1; s.use2 = 1'b1; end
         OP_CSRW:                 s.use1 = 1'b1;
         default:                 ;
      endcase
      return s;
   endfunction

   // A load still inside its latency window has no result to hand over yet.
   function automatic logic is_src(input stage_t s, input int k, input logic [4:0] r);
      return s.valid && s.wen && (s.rd != 5'd0) && (s.rd == r) && !(s.is_load && (k <= LOAD_LAT));
   endfunction

   stage_t      dec;
   stage_t      stg_q [1:DEPTH-1];
   stage_t      stg_d [1:DEPTH-1];
   logic        wb_en_q;
   logic [4:0]  wb_rd_q;
   logic [31:0] stall_cnt_q;
   logic        unused_inst_bits;

   assign unused_inst_bits = ^{in_inst[31:25], in_inst[14:12], in_inst[1:0]};

   always_comb begin : hazard
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      stall   = 1'b0;
      fwd1_s0 = '0;
      fwd2_s0 = '0;
      fwd1_s1 = '0;
      fwd2_s1 = '0;
      dec     = decode(in_inst);

      for (int k = 1; k <= LOAD_LAT; k++) begin
         if (in_valid && !redirect && stg_q[k].valid && stg_q[k].wen && stg_q[k].is_load &&
             (stg_q[k].rd != 5'd0) &&
             ((dec.use1 && (dec.rs1 == stg_q[k].rd)) || (dec.use2 && (dec.rs2 == stg_q[k].rd))))
            stall = 1'b1;
      end

      // Walk oldest to youngest so the youngest matching stage is written last.
      for (int k = DEPTH - 1; k >= 1; k--) begin
         if (in_valid && dec.use1 && (dec.rs1 != 5'd0) && is_src(stg_q[k], k, dec.rs1))
            fwd1_s0 = FW'(k);
         if (in_valid && dec.use2 && (dec.rs2 != 5'd0) && is_src(stg_q[k], k, dec.rs2))
            fwd2_s0 = FW'(k);
         if (k >= 2) begin
            if (stg_q[1].valid && stg_q[1].use1 && (stg_q[1].rs1 != 5'd0) && is_src(stg_q[k], k, stg_q[1].rs1))
               fwd1_s1 = FW'(k);
            if (stg_q[1].valid && stg_q[1].use2 && (stg_q[1].rs2 != 5'd0) && is_src(stg_q[k], k, stg_q[1].rs2))
               fwd2_s1 = FW'(k);
         end
      end
   end

   always_comb begin : shift
      stg_d[1] = (in_valid && !redirect && !stall) ? dec : '0;
      for (int k = 2; k < DEPTH; k++)
         stg_d[k] = stg_q[k-1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the stage records are a few flops, not a RAM, so they take the async reset too.
         for (int k = 1; k < DEPTH; k++)
            stg_q[k] <= '0;
         wb_en_q     <= 1'b0;
         wb_rd_q     <= 5'd0;
         stall_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking, so each stage samples its neighbour's pre-edge value.
         for (int k = 1; k < DEPTH; k++)
            stg_q[k] <= stg_d[k];
         wb_en_q <= stg_d[DEPTH-1].valid && stg_d[DEPTH-1].wen && (stg_d[DEPTH-1].rd != 5'd0);
         wb_rd_q <= stg_d[DEPTH-1].rd;
         if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign wb_en     = wb_en_q;
   assign wb_rd     = wb_rd_q;
   assign stall_cnt = stall_cnt_q;

endmodule
